// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Round-robin arbiter for N_REQ register-file write-back
//               requesters, with a registered write port and a 32-entry
//               pending-write scoreboard that drives read-hazard stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter int N_REQ = 3
) (
    input  logic                 clock,
    input  logic                 ctrl_reset,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [5*N_REQ-1:0]   req_reg,
    input  logic [32*N_REQ-1:0]  req_data,
    output logic [N_REQ-1:0]     req_ready,
    input  logic                 hold,
    input  logic                 claim_valid,
    input  logic [4:0]           claim_reg,
    output logic                 ctrl_writeEnable,
    output logic [4:0]           ctrl_writeReg,
    output logic [31:0]          data_writeReg,
    input  logic [4:0]           ctrl_readRegA,
    input  logic [4:0]           ctrl_readRegB,
    output logic                 stall_A,
    output logic                 stall_B,
    output logic [31:0]          busy
);

    // Pointer wide enough for N_REQ in 2..4.
    localparam int c_PW = (N_REQ > 2) ? 2 : 1;

    logic [c_PW-1:0]  r_rr_ptr;
    logic             r_we;
    logic [4:0]       r_wreg;
    logic [31:0]      r_wdata;
    logic [31:0]      r_busy;

    int               w_idx;
    int               w_gidx;
    logic             w_found;
    logic [N_REQ-1:0] w_grant;
    logic [4:0]       w_sel_reg;
    logic [31:0]      w_sel_data;
    logic [31:0]      w_set;
    logic [31:0]      w_clr;
    logic [c_PW-1:0]  w_ptr_next;

    // Round-robin search upward from the pointer, wrapping modulo N_REQ.
    always_comb begin
        w_found = 1'b0;
        w_gidx  = 0;
        w_idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = int'(r_rr_ptr) + k;
            if (w_idx >= N_REQ) begin
                w_idx = w_idx - N_REQ;
            end
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_gidx  = w_idx;
            end
        end
        // No grant while held or while reset is applied.
        if (hold || !ctrl_reset) begin
            w_found = 1'b0;
        end
        w_grant = '0;
        if (w_found) begin
            w_grant[w_gidx] = 1'b1;
        end
    end

    assign req_ready  = w_grant;
    assign w_sel_reg  = req_reg[w_gidx*5 +: 5];
    assign w_sel_data = req_data[w_gidx*32 +: 32];
    assign w_ptr_next = (w_gidx == N_REQ - 1) ? '0 : c_PW'(w_gidx + 1);

    // Scoreboard set (claim, never reg 0) and clear (write issuing this cycle).
    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (claim_valid && (claim_reg != 5'd0)) begin
            w_set[claim_reg] = 1'b1;
        end
        if (r_we) begin
            w_clr[r_wreg] = 1'b1;
        end
    end

    // Pointer, registered write port and scoreboard state.
    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            r_rr_ptr <= '0;
            r_we     <= 1'b0;
            r_wreg   <= 5'd0;
            r_wdata  <= 32'd0;
            r_busy   <= 32'd0;
        end else begin
            // Set is applied after clear so a simultaneous claim wins.
            r_busy <= ((r_busy & ~w_clr) | w_set) & ~32'd1;
            if (w_found) begin
                r_rr_ptr <= w_ptr_next;
                // Writes to register 0 are accepted but never enabled.
                r_we     <= (w_sel_reg != 5'd0);
                r_wreg   <= w_sel_reg;
                r_wdata  <= w_sel_data;
            end else begin
                r_we     <= 1'b0;
            end
        end
    end

    assign ctrl_writeEnable = r_we;
    assign ctrl_writeReg    = r_wreg;
    assign data_writeReg    = r_wdata;
    assign busy             = r_busy;
    assign stall_A          = r_busy[ctrl_readRegA];
    assign stall_B          = r_busy[ctrl_readRegB];

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Randomized and directed self-checking bench for
//               regfile_wb_arbiter against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    localparam int N = 3;

    logic            clock = 1'b0;
    logic            ctrl_reset = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [5*N-1:0]  req_reg = '0;
    logic [32*N-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic            hold = 1'b0;
    logic            claim_valid = 1'b0;
    logic [4:0]      claim_reg = '0;
    logic            ctrl_writeEnable;
    logic [4:0]      ctrl_writeReg;
    logic [31:0]     data_writeReg;
    logic [4:0]      ctrl_readRegA = '0;
    logic [4:0]      ctrl_readRegB = '0;
    logic            stall_A;
    logic            stall_B;
    logic [31:0]     busy;

    regfile_wb_arbiter #(.N_REQ(N)) u_dut (
        .clock(clock), .ctrl_reset(ctrl_reset),
        .req_valid(req_valid), .req_reg(req_reg), .req_data(req_data),
        .req_ready(req_ready), .hold(hold),
        .claim_valid(claim_valid), .claim_reg(claim_reg),
        .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
        .data_writeReg(data_writeReg),
        .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
        .stall_A(stall_A), .stall_B(stall_B), .busy(busy)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int          m_ptr;
    bit [31:0]   m_busy;
    bit          m_we;
    bit [4:0]    m_wreg;
    bit [31:0]   m_wdata;
    bit          m_wknown;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_busy = '0; m_we = 1'b0; m_wreg = '0; m_wdata = '0; m_wknown = 1'b1;
    endtask

    // Index of the requester that should be granted, -1 for none.
    function automatic int exp_grant();
        if (hold) return -1;
        for (int k = 0; k < N; k++) begin
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic set_in(input bit [N-1:0] v, input bit [4:0] r0, r1, r2,
                          input bit [31:0] d0, d1, d2, input bit h,
                          input bit cv, input bit [4:0] cr);
        req_valid = v; req_reg = {r2, r1, r0}; req_data = {d2, d1, d0};
        hold = h; claim_valid = cv; claim_reg = cr;
    endtask

    // One clock: called at a negedge with inputs applied.
    task automatic cycle();
        int g;
        bit [31:0] nb;
        #1;
        g = exp_grant();
        check("req_ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
        check("stall_A", 32'(stall_A), 32'(m_busy[ctrl_readRegA]));
        check("stall_B", 32'(stall_B), 32'(m_busy[ctrl_readRegB]));
        @(posedge clock);
        nb = m_busy;
        if (m_we) nb[m_wreg] = 1'b0;
        if (claim_valid && claim_reg != 0) nb[claim_reg] = 1'b1;
        m_busy = nb;
        if (g >= 0) begin
            m_ptr   = (g + 1) % N;
            m_wreg  = req_reg[5*g +: 5];
            m_wdata = req_data[32*g +: 32];
            m_we    = (m_wreg != 0);
            m_wknown = m_we;
        end else begin
            m_we = 1'b0;
        end
        @(negedge clock);
        check("writeEnable", 32'(ctrl_writeEnable), 32'(m_we));
        check("busy", busy, m_busy);
        if (m_wknown) begin
            check("writeReg", 32'(ctrl_writeReg), 32'(m_wreg));
            check("writeData", data_writeReg, m_wdata);
        end
    endtask

    task automatic check_reset_state();
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_stallA", 32'(stall_A), 32'd0);
        check("rst_stallB", 32'(stall_B), 32'd0);
        check("rst_we", 32'(ctrl_writeEnable), 32'd0);
        check("rst_wreg", 32'(ctrl_writeReg), 32'd0);
        check("rst_wdata", data_writeReg, 32'd0);
        check("rst_busy", busy, 32'd0);
    endtask

    initial begin
        model_reset();
        // Reset with activity on the inputs
        set_in(3'b111, 5'd3, 5'd4, 5'd5, 32'h1, 32'h2, 32'h3, 1'b0, 1'b1, 5'd3);
        ctrl_readRegA = 5'd3; ctrl_readRegB = 5'd4;
        repeat (2) @(negedge clock);
        check_reset_state();
        ctrl_reset = 1'b1;

        // Three requesters, regs 5/6/7, data A/B/C for three cycles
        set_in(3'b111, 5'd5, 5'd6, 5'd7, 32'hA, 32'hB, 32'hC, 1'b0, 1'b0, 5'd0);
        ctrl_readRegA = 5'd0; ctrl_readRegB = 5'd0;
        repeat (3) cycle();
        set_in(3'b000, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1'b0, 1'b0, 5'd0);
        cycle();

        // Claim reg 9, observe the stall, then requester 1 writes reg 9
        ctrl_readRegA = 5'd9;
        set_in(3'b000, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1'b0, 1'b1, 5'd9);
        cycle();
        set_in(3'b000, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1'b0, 1'b0, 5'd0);
        cycle();
        check("stall_A_claimed", 32'(stall_A), 32'd1);
        set_in(3'b010, 5'd0, 5'd9, 5'd0, 0, 32'h9999, 0, 1'b0, 1'b0, 5'd0);
        cycle();
        set_in(3'b000, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1'b0, 1'b0, 5'd0);
        cycle();
        check("stall_A_cleared", 32'(stall_A), 32'd0);

        // Claim 9 at the same edge its write issues: set wins
        set_in(3'b000, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1'b0, 1'b1, 5'd9);
        cycle();
        set_in(3'b001, 5'd9, 5'd0, 5'd0, 32'h1234, 0, 0, 1'b0, 1'b0, 5'd0);
        cycle();
        set_in(3'b000, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1'b0, 1'b1, 5'd9);
        cycle();
        check("busy9_set_wins", 32'(busy[9]), 32'd1);
        set_in(3'b000, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1'b0, 1'b0, 5'd0);
        cycle();

        // Write to reg 0 and claim of reg 0
        ctrl_readRegA = 5'd0;
        set_in(3'b001, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFF, 0, 0, 1'b0, 1'b1, 5'd0);
        cycle();
        set_in(3'b000, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1'b0, 1'b0, 5'd0);
        cycle();
        check("busy0", 32'(busy[0]), 32'd0);

        // Hold with all valid, then release
        set_in(3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 1'b1, 1'b0, 5'd0);
        repeat (2) cycle();
        hold = 1'b0;
        cycle();

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            req_valid     = N'($urandom);
            req_reg       = 15'($urandom);
            req_data      = {$urandom, $urandom, $urandom};
            hold          = ($urandom_range(0, 4) == 0);
            claim_valid   = $urandom_range(0, 1) == 1;
            claim_reg     = 5'($urandom_range(0, 31));
            ctrl_readRegA = 5'($urandom);
            ctrl_readRegB = 5'($urandom);
            cycle();
        end

        // Reset asserted at an edge where a transfer is granted
        set_in(3'b111, 5'd20, 5'd21, 5'd22, 32'h20, 32'h21, 32'h22, 1'b0, 1'b1, 5'd20);
        #1;
        check("pre_rst_grant", 32'(|req_ready), 32'd1);
        @(posedge clock);
        ctrl_reset = 1'b0;
        model_reset();
        @(negedge clock);
        check_reset_state();
        ctrl_reset = 1'b1;
        set_in(3'b111, 5'd10, 5'd11, 5'd12, 32'h10, 32'h11, 32'h12, 1'b0, 1'b0, 5'd0);
        #1;
        check("post_rst_grant0", 32'(req_ready), 32'd1);
        @(negedge clock);
        set_in(3'b111, 5'd10, 5'd11, 5'd12, 32'h10, 32'h11, 32'h12, 1'b0, 1'b0, 5'd0);
        check("post_rst_we", 32'(ctrl_writeEnable), 32'd1);
        check("post_rst_wreg", 32'(ctrl_writeReg), 32'd10);
        m_ptr = 1; m_we = 1'b1; m_wreg = 5'd10; m_wdata = 32'h10; m_wknown = 1'b1;
        repeat (2) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
